sa_psum_drain: RTL and testbench
================================

SA_PSUM_DRAIN -- requirements
Module: sa_psum_drain

Parameters
REQ-001 The block SHALL have parameter ADD_DATAWIDTH, default 8, giving the width of one partial sum.
REQ-002 The block SHALL have parameter NUM_COLS, default 4, giving the number of array columns.
REQ-003 The block SHALL have parameter NUM_ROWS, default 4, giving the number of output rows per tile.
REQ-004 The block SHALL have parameter DEPTH, default 4, giving the output FIFO entry count (power of 2, ≥2).

Interface
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 i_valid  input  1  column-0 result of one output row present on i_psum[0] this cycle.
REQ-008 i_psum  input  [ADD_DATAWIDTH-1:0] x NUM_COLS  skewed column results (array o_psum).
REQ-009 i_ready  input  1  consumer accepts o_row this cycle.
REQ-010 o_valid  output  1  FIFO non-empty; o_row holds the head row.
REQ-011 o_row  output  [ADD_DATAWIDTH-1:0] x NUM_COLS  deskewed row, index c = column c.
REQ-012 o_tile_done  output  1  one-cycle pulse when the NUM_ROWS-th row of a tile is written.
REQ-013 o_overflow  output  1  sticky; a row was dropped because the FIFO was full.

Function
REQ-014 Skew contract: for i_valid high in cycle t, the column-c value SHALL be sampled from i_psum[c] in cycle t+c.
REQ-015 Deskew: i_psum[c] SHALL pass through NUM_COLS-1-c register stages, and i_valid through NUM_COLS-1 stages, so all columns align in cycle t+NUM_COLS-1.
REQ-016 i_valid MAY be high on consecutive cycles; each row SHALL be deskewed independently without corruption.
REQ-017 An aligned row SHALL be written to the FIFO on the edge ending cycle t+NUM_COLS-1, giving o_valid high in cycle t+NUM_COLS (latency NUM_COLS) when the FIFO was empty.
REQ-018 FIFO order SHALL be first-in first-out.
REQ-019 o_valid SHALL equal FIFO not-empty.
REQ-020 A pop SHALL occur on an edge where o_valid && i_ready; i_ready with o_valid low SHALL have no effect.
REQ-021 o_row SHALL be all-zero whenever o_valid is low.
REQ-022 Full FIFO with an aligned row and no pop in the same cycle: the row SHALL be dropped, FIFO contents unchanged, and o_overflow set from the next cycle.
REQ-023 Full FIFO with an aligned row and a simultaneous pop: push and pop SHALL both succeed with no overflow.
REQ-024 Empty FIFO: push and pop cannot coincide, because o_valid is low.
REQ-025 Row counter SHALL count aligned rows from 0 to NUM_ROWS-1, including dropped rows, and wrap to 0.
REQ-026 o_tile_done SHALL be high in the cycle after the edge on which the count wraps, for exactly one cycle.
REQ-027 o_overflow SHALL clear only on rst.
REQ-028 Pointers SHALL wrap modulo DEPTH; full/empty SHALL be distinguished by an extra pointer bit or an occupancy counter.
REQ-029 No arithmetic SHALL be performed on data; widths pass through unchanged.

Reset
REQ-030 While rst is high on an edge, the block SHALL clear FIFO pointers/occupancy, all deskew valid stages, the row counter, o_overflow and o_tile_done.
REQ-031 The cycle after reset, the outputs SHALL be: o_valid=0, o_row=0, o_tile_done=0, o_overflow=0.
REQ-032 Rows in flight in the deskew pipeline at reset SHALL be discarded and never emitted.
REQ-033 Deskew data registers need not be reset.

Verification (NUM_COLS=NUM_ROWS=DEPTH=4, ADD_DATAWIDTH=8; cycle 0 = first i_valid)
REQ-034 Single row: i_valid in cycle 0, i_psum[c]=10+c in cycle c, i_ready=1 -> o_valid only in cycle 4 with o_row={10,11,12,13}.
REQ-035 Back-to-back tile: i_valid cycles 0-3, row r column c = 16*r+c, i_ready=1 -> rows 0..3 in cycles 4..7 in order, o_tile_done high in cycle 7 only.
REQ-036 Overflow: i_ready=0, five rows (i_valid cycles 0-4) -> four rows stored, o_overflow=1 from cycle 8 and remains high; i_ready=1 from cycle 10 -> rows 0..3 in order, row 4 never appears, o_tile_done pulses in cycle 7.
REQ-037 Full with pop: FIFO holding 4 rows, fifth row aligns in the same cycle that i_ready=1 -> no overflow, fifth row emitted after the fourth.
REQ-038 Reset mid-flight: i_valid in cycle 0, rst high in cycle 2 -> o_valid stays 0 afterwards, all outputs 0, and a new row at cycle 5 emerges in cycle 9 correctly.
REQ-039 Idle ready: i_ready=1 with FIFO empty for 10 cycles -> o_valid=0 throughout, and a subsequent row is emitted intact.

Source files
------------

// File: rtl/sa_psum_drain.sv
// sa_psum_drain
//   Collects the skewed column results leaving a systolic array, realigns
//   them into whole output rows, and buffers those rows in a small FIFO
//   for a ready/valid consumer. It also counts rows per tile and raises a
//   sticky flag whenever a row is lost because the FIFO was full.
//
// Ports
//   clk          sole clock, all state changes on its rising edge
//   rst          synchronous active-high reset
//   i_valid      column 0 of a new row is present on i_psum[0] this cycle
//   i_psum[c]    column c result, arriving c cycles after its i_valid
//   i_ready      consumer takes o_row this cycle
//   o_valid      FIFO is non-empty and o_row holds the oldest row
//   o_row[c]     realigned row, column c (zero while o_valid is low)
//   o_tile_done  one-cycle pulse after the last row of a tile is written
//   o_overflow   sticky, set when a row was dropped on a full FIFO

module sa_psum_drain #(
  parameter int ADD_DATAWIDTH = 8,
  parameter int NUM_COLS      = 4,
  parameter int NUM_ROWS      = 4,
  parameter int DEPTH         = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_valid,
  input  logic [ADD_DATAWIDTH-1:0] i_psum [NUM_COLS],
  input  logic                     i_ready,
  output logic                     o_valid,
  output logic [ADD_DATAWIDTH-1:0] o_row [NUM_COLS],
  output logic                     o_tile_done,
  output logic                     o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

  logic [ADD_DATAWIDTH-1:0] aligned_row [NUM_COLS];
  logic                     aligned_valid;

  // The row marker travels the full NUM_COLS-1 stages so that it lines up
  // with the last column, which needs no delay at all.
  generate
    if (NUM_COLS == 1) begin : g_valid_direct
      assign aligned_valid = i_valid;
    end else begin : g_valid_pipe
      logic [NUM_COLS-2:0] valid_sr;

      always_ff @(posedge clk) begin
        if (rst) begin
          valid_sr <= '0;
        end else begin
          valid_sr[0] <= i_valid;
          for (int s = 1; s < NUM_COLS - 1; s++) begin
            valid_sr[s] <= valid_sr[s-1];
          end
        end
      end

      assign aligned_valid = valid_sr[NUM_COLS-2];
    end
  endgenerate

  // Column c arrives c cycles late, so it is held for the remaining
  // NUM_COLS-1-c cycles. Data stages carry no reset; only the valid
  // marker decides whether anything is kept.
  generate
    for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
      if (c == NUM_COLS - 1) begin : g_pass
        assign aligned_row[c] = i_psum[c];
      end else begin : g_delay
        localparam int STAGES = NUM_COLS - 1 - c;
        logic [ADD_DATAWIDTH-1:0] data_sr [STAGES];

        always_ff @(posedge clk) begin
          data_sr[0] <= i_psum[c];
          for (int s = 1; s < STAGES; s++) begin
            data_sr[s] <= data_sr[s-1];
          end
        end

        assign aligned_row[c] = data_sr[STAGES-1];
      end
    end
  endgenerate

  logic [ADD_DATAWIDTH-1:0] mem [DEPTH][NUM_COLS];
  logic [AW:0]              wr_ptr;
  logic [AW:0]              rd_ptr;
  logic [AW-1:0]            wr_idx;
  logic [AW-1:0]            rd_idx;
  logic                     empty;
  logic                     full;
  logic                     pop;
  logic                     push;
  logic                     drop;
  logic [RW-1:0]            row_cnt;

  assign wr_idx = wr_ptr[AW-1:0];
  assign rd_idx = rd_ptr[AW-1:0];

  // The extra pointer bit tells a full FIFO (same index, different lap)
  // apart from an empty one (identical pointers).
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);

  // A pop frees the head slot on the same edge, so a full FIFO still
  // accepts a row while it is being drained.
  assign pop  = !empty && i_ready;
  assign push = aligned_valid && (!full || pop);
  assign drop = aligned_valid && full && !pop;

  assign o_valid = !empty;

  always_comb begin
    for (int c = 0; c < NUM_COLS; c++) begin
      o_row[c] = o_valid ? mem[rd_idx][c] : '0;
    end
  end

  // Row storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      for (int c = 0; c < NUM_COLS; c++) begin
        mem[wr_idx][c] <= aligned_row[c];
      end
    end
  end

  // Pointer, tile counter and status flags. Every aligned row advances the
  // tile count, including rows dropped on overflow, so tile boundaries
  // stay in step with the array even when data is lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      row_cnt     <= '0;
      o_tile_done <= 1'b0;
      o_overflow  <= 1'b0;
    end else begin
      o_tile_done <= 1'b0;
      if (push) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
      if (drop) begin
        o_overflow <= 1'b1;
      end
      if (aligned_valid) begin
        if (row_cnt == RW'(NUM_ROWS - 1)) begin
          row_cnt     <= '0;
          o_tile_done <= 1'b1;
        end else begin
          row_cnt <= row_cnt + RW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_sa_psum_drain.sv
// tb_sa_psum_drain
//   Drives skewed rows into sa_psum_drain and compares every cycle against
//   a queue-based reference: a row issued in cycle t becomes a complete
//   row NUM_COLS-1 cycles later and then follows plain FIFO rules.
//
// Ports: none (self-contained bench, clock generated here).

module tb_sa_psum_drain;

  localparam int W  = 8;
  localparam int NC = 4;
  localparam int NR = 4;
  localparam int D  = 4;

  typedef logic [NC-1:0][W-1:0] row_t;

  typedef struct {
    row_t data;
    int   align;
  } pend_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_valid;
  logic [W-1:0] i_psum [NC];
  logic         i_ready;
  logic         o_valid;
  logic [W-1:0] o_row [NC];
  logic         o_tile_done;
  logic         o_overflow;

  sa_psum_drain #(
    .ADD_DATAWIDTH(W),
    .NUM_COLS     (NC),
    .NUM_ROWS     (NR),
    .DEPTH        (D)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_valid    (i_valid),
    .i_psum     (i_psum),
    .i_ready    (i_ready),
    .o_valid    (o_valid),
    .o_row      (o_row),
    .o_tile_done(o_tile_done),
    .o_overflow (o_overflow)
  );

  always #5 clk = ~clk;

  int    n_cmp  = 0;
  int    n_fail = 0;
  int    cyc    = 0;
  row_t  issued [int];
  pend_t pend_q [$];
  row_t  m_fifo [$];
  int    m_rows = 0;
  bit    m_tile_done = 1'b0;
  bit    m_overflow  = 1'b0;

  // Reference model outputs for the current cycle.
  function automatic row_t model_head();
    row_t r;
    r = '0;
    if (m_fifo.size() != 0) r = m_fifo[0];
    return r;
  endfunction

  function automatic bit model_valid();
    return m_fifo.size() != 0;
  endfunction

  function automatic row_t got_row();
    row_t r;
    for (int c = 0; c < NC; c++) r[c] = o_row[c];
    return r;
  endfunction

  function automatic row_t rand_row();
    row_t r;
    for (int c = 0; c < NC; c++) r[c] = W'($urandom);
    return r;
  endfunction

  // Drives one clock cycle: presents i_valid / i_ready / rst, places each
  // column of every issued row on its skewed slot (random filler
  // elsewhere) and advances the reference model across the coming edge.
  task automatic drive_cycle(input bit v, input row_t data, input bit rdy, input bit r);
    pend_t p;
    int    sz;
    bit    pop;
    bit    aligned;
    row_t  arow;
    arow = '0;
    if (v) begin
      issued[cyc] = data;
      if (!r) begin
        p.data  = data;
        p.align = cyc + NC - 1;
        pend_q.push_back(p);
      end
    end
    rst     = r;
    i_valid = v;
    i_ready = rdy;
    for (int c = 0; c < NC; c++) begin
      i_psum[c] = issued.exists(cyc - c) ? issued[cyc - c][c] : W'($urandom);
    end
    if (r) begin
      pend_q.delete();
      m_fifo.delete();
      m_rows      = 0;
      m_tile_done = 1'b0;
      m_overflow  = 1'b0;
    end else begin
      sz      = m_fifo.size();
      pop     = (sz != 0) && rdy;
      aligned = 1'b0;
      if (pend_q.size() != 0 && pend_q[0].align == cyc) begin
        aligned = 1'b1;
        arow    = pend_q[0].data;
        void'(pend_q.pop_front());
      end
      m_tile_done = 1'b0;
      if (aligned) begin
        m_rows++;
        if (m_rows == NR) begin
          m_rows      = 0;
          m_tile_done = 1'b1;
        end
      end
      if (pop) void'(m_fifo.pop_front());
      if (aligned) begin
        if (sz < D || pop) m_fifo.push_back(arow);
        else m_overflow = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    drive_cycle(1'b0, '0, 1'b1, 1'b1);
  endtask

  task automatic test_reset();
    drive_cycle(1'b1, rand_row(), 1'b1, 1'b1);
    drive_cycle(1'b1, rand_row(), 1'b0, 1'b1);
    n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid: got %b want 0", o_valid); end
    n_cmp++; if (got_row() !== row_t'(0)) begin n_fail++; $display("[TB] FAIL reset_row: got %h want 0", got_row()); end
    n_cmp++; if (o_tile_done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_tile_done: got %b want 0", o_tile_done); end
    n_cmp++; if (o_overflow !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_overflow: got %b want 0", o_overflow); end
  endtask

  task automatic test_single_row();
    row_t row;
    int   base;
    int   rel;
    for (int c = 0; c < NC; c++) row[c] = W'(10 + c);
    do_reset();
    base = cyc;
    for (int k = 0; k < 9; k++) begin
      drive_cycle(k == 0, row, 1'b1, 1'b0);
      rel = cyc - base;
      n_cmp++; if (o_valid !== (rel == 4)) begin n_fail++; $display("[TB] FAIL single_valid c%0d: got %b want %b", rel, o_valid, rel == 4); end
      n_cmp++; if (got_row() !== model_head()) begin n_fail++; $display("[TB] FAIL single_row c%0d: got %h want %h", rel, got_row(), model_head()); end
      n_cmp++; if (o_tile_done !== m_tile_done) begin n_fail++; $display("[TB] FAIL single_tile c%0d: got %b want %b", rel, o_tile_done, m_tile_done); end
      if (rel == 4) begin
        n_cmp++; if (got_row() !== row) begin n_fail++; $display("[TB] FAIL single_data: got %h want %h", got_row(), row); end
      end
    end
  endtask

  task automatic test_back_to_back();
    row_t rows [4];
    int   base;
    int   rel;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < NC; c++) rows[r][c] = W'(16 * r + c);
    do_reset();
    base = cyc;
    for (int k = 0; k < 11; k++) begin
      drive_cycle(k < 4, rows[k % 4], 1'b1, 1'b0);
      rel = cyc - base;
      n_cmp++; if (o_valid !== (rel >= 4 && rel <= 7)) begin n_fail++; $display("[TB] FAIL b2b_valid c%0d: got %b", rel, o_valid); end
      n_cmp++; if (got_row() !== model_head()) begin n_fail++; $display("[TB] FAIL b2b_row c%0d: got %h want %h", rel, got_row(), model_head()); end
      n_cmp++; if (o_tile_done !== (rel == 7)) begin n_fail++; $display("[TB] FAIL b2b_tile c%0d: got %b want %b", rel, o_tile_done, rel == 7); end
      n_cmp++; if (o_overflow !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_overflow c%0d: got %b want 0", rel, o_overflow); end
      if (rel >= 4 && rel <= 7) begin
        n_cmp++; if (got_row() !== rows[rel - 4]) begin n_fail++; $display("[TB] FAIL b2b_data c%0d: got %h want %h", rel, got_row(), rows[rel - 4]); end
      end
    end
  endtask

  task automatic test_overflow();
    row_t rows [5];
    int   base;
    int   rel;
    for (int r = 0; r < 5; r++) rows[r] = rand_row();
    do_reset();
    base = cyc;
    for (int k = 0; k < 17; k++) begin
      drive_cycle(k < 5, rows[k % 5], k >= 10, 1'b0);
      rel = cyc - base;
      n_cmp++; if (o_overflow !== (rel >= 8)) begin n_fail++; $display("[TB] FAIL ovf_flag c%0d: got %b want %b", rel, o_overflow, rel >= 8); end
      n_cmp++; if (o_tile_done !== (rel == 7)) begin n_fail++; $display("[TB] FAIL ovf_tile c%0d: got %b want %b", rel, o_tile_done, rel == 7); end
      n_cmp++; if (o_valid !== model_valid()) begin n_fail++; $display("[TB] FAIL ovf_valid c%0d: got %b want %b", rel, o_valid, model_valid()); end
      n_cmp++; if (got_row() !== model_head()) begin n_fail++; $display("[TB] FAIL ovf_row c%0d: got %h want %h", rel, got_row(), model_head()); end
      if (rel >= 10 && rel <= 13) begin
        n_cmp++; if (got_row() !== rows[rel - 10]) begin n_fail++; $display("[TB] FAIL ovf_data c%0d: got %h want %h", rel, got_row(), rows[rel - 10]); end
      end
      if (rel >= 14) begin
        n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL ovf_dropped c%0d: got valid %b want 0", rel, o_valid); end
      end
    end
  endtask

  task automatic test_full_pop();
    row_t rows [5];
    int   base;
    int   rel;
    for (int r = 0; r < 5; r++) rows[r] = rand_row();
    do_reset();
    base = cyc;
    for (int k = 0; k < 15; k++) begin
      drive_cycle(k < 5, rows[k % 5], (k == 7) || (k >= 9), 1'b0);
      rel = cyc - base;
      n_cmp++; if (o_overflow !== 1'b0) begin n_fail++; $display("[TB] FAIL fullpop_overflow c%0d: got %b want 0", rel, o_overflow); end
      n_cmp++; if (o_valid !== model_valid()) begin n_fail++; $display("[TB] FAIL fullpop_valid c%0d: got %b want %b", rel, o_valid, model_valid()); end
      n_cmp++; if (got_row() !== model_head()) begin n_fail++; $display("[TB] FAIL fullpop_row c%0d: got %h want %h", rel, got_row(), model_head()); end
      if (rel >= 9 && rel <= 12) begin
        n_cmp++; if (got_row() !== rows[rel - 8]) begin n_fail++; $display("[TB] FAIL fullpop_data c%0d: got %h want %h", rel, got_row(), rows[rel - 8]); end
      end
    end
  endtask

  task automatic test_reset_midflight();
    row_t ra;
    row_t rb;
    int   base;
    int   rel;
    ra = rand_row();
    rb = rand_row();
    do_reset();
    base = cyc;
    for (int k = 0; k < 13; k++) begin
      drive_cycle(k == 0 || k == 5, (k == 0) ? ra : rb, 1'b1, k == 2);
      rel = cyc - base;
      n_cmp++; if (o_valid !== (rel == 9)) begin n_fail++; $display("[TB] FAIL midrst_valid c%0d: got %b want %b", rel, o_valid, rel == 9); end
      n_cmp++; if (got_row() !== model_head()) begin n_fail++; $display("[TB] FAIL midrst_row c%0d: got %h want %h", rel, got_row(), model_head()); end
      n_cmp++; if (o_tile_done !== 1'b0 || o_overflow !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_flags c%0d: got %b%b want 00", rel, o_tile_done, o_overflow); end
      if (rel == 9) begin
        n_cmp++; if (got_row() !== rb) begin n_fail++; $display("[TB] FAIL midrst_data: got %h want %h", got_row(), rb); end
      end
    end
  endtask

  task automatic test_idle_ready();
    row_t row;
    int   base;
    int   rel;
    row = rand_row();
    do_reset();
    base = cyc;
    for (int k = 0; k < 17; k++) begin
      drive_cycle(k == 10, row, 1'b1, 1'b0);
      rel = cyc - base;
      n_cmp++; if (o_valid !== (rel == 14)) begin n_fail++; $display("[TB] FAIL idle_valid c%0d: got %b want %b", rel, o_valid, rel == 14); end
      n_cmp++; if (got_row() !== ((rel == 14) ? row : row_t'(0))) begin n_fail++; $display("[TB] FAIL idle_row c%0d: got %h", rel, got_row()); end
    end
  endtask

  task automatic test_random();
    bit v;
    bit rdy;
    do_reset();
    for (int k = 0; k < 600; k++) begin
      v   = 1'($urandom_range(0, 1));
      rdy = ((k / 100) % 2 == 1) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 3) != 0);
      drive_cycle(v, rand_row(), rdy, k == 450);
      n_cmp++; if (o_valid !== model_valid()) begin n_fail++; $display("[TB] FAIL rand_valid k%0d: got %b want %b", k, o_valid, model_valid()); end
      n_cmp++; if (got_row() !== model_head()) begin n_fail++; $display("[TB] FAIL rand_row k%0d: got %h want %h", k, got_row(), model_head()); end
      n_cmp++; if (o_tile_done !== m_tile_done) begin n_fail++; $display("[TB] FAIL rand_tile k%0d: got %b want %b", k, o_tile_done, m_tile_done); end
      n_cmp++; if (o_overflow !== m_overflow) begin n_fail++; $display("[TB] FAIL rand_overflow k%0d: got %b want %b", k, o_overflow, m_overflow); end
    end
  endtask

  // Guards against a stuck simulation.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Scenario sequence.
  initial begin
    rst     = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b0;
    for (int c = 0; c < NC; c++) i_psum[c] = '0;
    test_reset();
    test_single_row();
    test_back_to_back();
    test_overflow();
    test_full_pop();
    test_reset_midflight();
    test_idle_ready();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
